// File: rtl/icache_refill_ctrl.sv
// Miss/refill sequencer for the direct-mapped instruction cache.
// Optional memory-request timeout with sticky ERR: define ICACHE_REFILL_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | watching HitWrite; miss latches address/index and raises MM_REQ
// REQ    | MM_REQ held until MM_RDY (or timeout when enabled)
// FILL   | one-cycle Access_MM strobe with the captured word
// SETTLE | one cycle for the cache's registered hit flag to update
module icache_refill_ctrl #(
  parameter int INDEX_W = 3,
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 64
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [31:0]        PC,
  input  logic               HitWrite,
  input  logic               MM_RDY,
  input  logic [31:0]        MM_RDATA,
  output logic               MM_REQ,
  output logic [31:0]        MM_ADDR,
  output logic [INDEX_W-1:0] index,
  output logic               Access_MM,
  output logic [31:0]        Data_MM,
  output logic               STALL,
  output logic               BUSY,
  output logic               ERR,
  output logic [CNT_W-1:0]   CNT_REFILL,
  output logic [CNT_W-1:0]   CNT_STALL
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    FILL   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_mm_req;
  logic [31:0]        r_mm_addr;
  logic [31:0]        r_data;
  logic [INDEX_W-1:0] r_index;
  logic [CNT_W-1:0]   r_cnt_refill;
  logic [CNT_W-1:0]   r_cnt_stall;
  logic               w_miss;
  logic               w_rdy;
  logic               w_timeout;
  logic               w_unused;

  assign w_miss   = (r_state == IDLE) && !HitWrite;
  assign w_rdy    = (r_state == REQ) && MM_RDY;
  assign w_unused = &{1'b0, PC[1:0]};

`ifdef ICACHE_REFILL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  // Down-counter loaded on the miss; terminal count in REQ without MM_RDY aborts.
  assign w_timeout = (r_state == REQ) && !MM_RDY && (r_to_cnt == '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_miss)
        r_to_cnt <= TO_W'(TIMEOUT - 1);
      else if ((r_state == REQ) && (r_to_cnt != '0))
        r_to_cnt <= r_to_cnt - 1'b1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign ERR = r_err;
`else
  localparam int unused_timeout = TIMEOUT;

  assign w_timeout = 1'b0;
  assign ERR       = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!HitWrite) w_next = REQ;
      REQ: begin
        if (MM_RDY)
          w_next = FILL;
        else if (w_timeout)
          w_next = IDLE;
      end
      FILL:    w_next = SETTLE;
      SETTLE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    STALL     = 1'b1;
    BUSY      = 1'b1;
    Access_MM = 1'b0;
    index     = r_index;
    case (r_state)
      IDLE: begin
        STALL = ~HitWrite;
        BUSY  = 1'b0;
        index = PC[INDEX_W+1:2];
      end
      FILL:    Access_MM = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mm_req  <= 1'b0;
      r_mm_addr <= '0;
      r_data    <= '0;
      r_index   <= '0;
    end else begin
      if (w_miss) begin
        r_mm_req  <= 1'b1;
        r_mm_addr <= {PC[31:2], 2'b00};
        r_index   <= PC[INDEX_W+1:2];
      end
      if (w_rdy) begin
        r_mm_req <= 1'b0;
        r_data   <= MM_RDATA;
      end else if (w_timeout) begin
        r_mm_req <= 1'b0;
      end
    end
  end

  // Statistics saturate at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt_refill <= '0;
      r_cnt_stall  <= '0;
    end else begin
      if ((r_state == FILL) && (r_cnt_refill != '1))
        r_cnt_refill <= r_cnt_refill + 1'b1;
      if (STALL && (r_cnt_stall != '1))
        r_cnt_stall <= r_cnt_stall + 1'b1;
    end
  end

  assign MM_REQ     = r_mm_req;
  assign MM_ADDR    = r_mm_addr;
  assign Data_MM    = r_data;
  assign CNT_REFILL = r_cnt_refill;
  assign CNT_STALL  = r_cnt_stall;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: schedule-based reference model of
// each refill (4+W stall cycles) with saturating statistics.
module tb_icache_refill_ctrl;
  localparam int INDEX_W = 3;
  localparam int CNT_W   = 20;
  localparam int TIMEOUT = 8;

  logic               CLK = 1'b0;
  logic               RESET_N;
  logic [31:0]        PC;
  logic               HitWrite;
  logic               MM_RDY;
  logic [31:0]        MM_RDATA;
  logic               MM_REQ;
  logic [31:0]        MM_ADDR;
  logic [INDEX_W-1:0] index;
  logic               Access_MM;
  logic [31:0]        Data_MM;
  logic               STALL;
  logic               BUSY;
  logic               ERR;
  logic [CNT_W-1:0]   CNT_REFILL;
  logic [CNT_W-1:0]   CNT_STALL;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_refill;
  logic [CNT_W-1:0] exp_stall;
  logic             exp_err;

  icache_refill_ctrl #(.INDEX_W(INDEX_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PC(PC), .HitWrite(HitWrite),
    .MM_RDY(MM_RDY), .MM_RDATA(MM_RDATA), .MM_REQ(MM_REQ), .MM_ADDR(MM_ADDR),
    .index(index), .Access_MM(Access_MM), .Data_MM(Data_MM), .STALL(STALL),
    .BUSY(BUSY), .ERR(ERR), .CNT_REFILL(CNT_REFILL), .CNT_STALL(CNT_STALL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [INDEX_W-1:0] idx_of(input logic [31:0] a);
    return a[INDEX_W+1:2];
  endfunction

  task automatic apply_reset();
    @(negedge CLK);
    RESET_N  = 1'b0;
    HitWrite = 1'b1;
    MM_RDY   = 1'b0;
    @(negedge CLK);
    RESET_N    = 1'b1;
    exp_refill = '0;
    exp_stall  = '0;
    exp_err    = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      PC       = $urandom;
      HitWrite = 1'b1;
      MM_RDY   = 1'($urandom);
      MM_RDATA = $urandom;
      #1;
      checks++;
      if (STALL !== 1'b0 || BUSY !== 1'b0 || Access_MM !== 1'b0 || MM_REQ !== 1'b0) begin
        errors++;
        $display("FAIL idle_ctrl: got stall=%b busy=%b acc=%b req=%b expected 0 0 0 0",
                 STALL, BUSY, Access_MM, MM_REQ);
      end
      checks++;
      if (index !== idx_of(PC)) begin
        errors++;
        $display("FAIL idle_index: got %0d expected %0d", index, idx_of(PC));
      end
      checks++;
      if (CNT_STALL !== exp_stall || CNT_REFILL !== exp_refill || ERR !== exp_err) begin
        errors++;
        $display("FAIL idle_stats: got stall_cnt=%0h refill=%0h err=%b expected %0h %0h %b",
                 CNT_STALL, CNT_REFILL, ERR, exp_stall, exp_refill, exp_err);
      end
    end
  endtask

  // One full refill: detect cycle, 1+w REQ cycles, FILL, SETTLE.
  task automatic run_miss(input logic [31:0] pc, input logic [31:0] data, input int w);
    logic [31:0]        ma;
    logic [INDEX_W-1:0] ix;
    ma = {pc[31:2], 2'b00};
    ix = idx_of(pc);

    @(negedge CLK);
    PC       = pc;
    HitWrite = 1'b0;
    MM_RDY   = 1'($urandom);
    MM_RDATA = $urandom;
    #1;
    checks++;
    if (STALL !== 1'b1 || BUSY !== 1'b0 || MM_REQ !== 1'b0 || index !== ix) begin
      errors++;
      $display("FAIL detect: got stall=%b busy=%b req=%b idx=%0d expected 1 0 0 %0d",
               STALL, BUSY, MM_REQ, index, ix);
    end
    checks++;
    if (CNT_STALL !== exp_stall || CNT_REFILL !== exp_refill || ERR !== exp_err) begin
      errors++;
      $display("FAIL detect_stats: got stall_cnt=%0h refill=%0h err=%b expected %0h %0h %b",
               CNT_STALL, CNT_REFILL, ERR, exp_stall, exp_refill, exp_err);
    end
    exp_stall = sat_inc(exp_stall);

    for (int k = 0; k <= w; k++) begin
      @(negedge CLK);
      PC       = $urandom;
      HitWrite = 1'($urandom);
      MM_RDY   = (k == w);
      MM_RDATA = (k == w) ? data : $urandom;
      #1;
      checks++;
      if (MM_REQ !== 1'b1 || MM_ADDR !== ma) begin
        errors++;
        $display("FAIL req: got req=%b addr=%08h expected 1 %08h", MM_REQ, MM_ADDR, ma);
      end
      checks++;
      if (STALL !== 1'b1 || BUSY !== 1'b1 || Access_MM !== 1'b0 || index !== ix) begin
        errors++;
        $display("FAIL req_ctrl: got stall=%b busy=%b acc=%b idx=%0d expected 1 1 0 %0d",
                 STALL, BUSY, Access_MM, index, ix);
      end
      checks++;
      if (CNT_STALL !== exp_stall) begin
        errors++;
        $display("FAIL req_stall_cnt: got %0h expected %0h", CNT_STALL, exp_stall);
      end
      exp_stall = sat_inc(exp_stall);
    end

    @(negedge CLK);
    PC       = $urandom;
    HitWrite = 1'($urandom);
    MM_RDY   = 1'($urandom);
    MM_RDATA = $urandom;
    #1;
    checks++;
    if (Access_MM !== 1'b1 || index !== ix || Data_MM !== data) begin
      errors++;
      $display("FAIL fill: got acc=%b idx=%0d data=%08h expected 1 %0d %08h",
               Access_MM, index, Data_MM, ix, data);
    end
    checks++;
    if (MM_REQ !== 1'b0 || STALL !== 1'b1 || BUSY !== 1'b1 || CNT_STALL !== exp_stall) begin
      errors++;
      $display("FAIL fill_ctrl: got req=%b stall=%b busy=%b stall_cnt=%0h expected 0 1 1 %0h",
               MM_REQ, STALL, BUSY, CNT_STALL, exp_stall);
    end
    exp_stall  = sat_inc(exp_stall);
    exp_refill = sat_inc(exp_refill);

    @(negedge CLK);
    PC       = $urandom;
    HitWrite = 1'($urandom);
    MM_RDY   = 1'($urandom);
    MM_RDATA = $urandom;
    #1;
    checks++;
    if (Access_MM !== 1'b0 || STALL !== 1'b1 || BUSY !== 1'b1 || index !== ix) begin
      errors++;
      $display("FAIL settle: got acc=%b stall=%b busy=%b idx=%0d expected 0 1 1 %0d",
               Access_MM, STALL, BUSY, index, ix);
    end
    checks++;
    if (CNT_REFILL !== exp_refill || CNT_STALL !== exp_stall || ERR !== exp_err) begin
      errors++;
      $display("FAIL settle_stats: got refill=%0h stall_cnt=%0h err=%b expected %0h %0h %b",
               CNT_REFILL, CNT_STALL, ERR, exp_refill, exp_stall, exp_err);
    end
    exp_stall = sat_inc(exp_stall);
  endtask

  task automatic test_reset();
    RESET_N  = 1'b0;
    PC       = '0;
    HitWrite = 1'b1;
    MM_RDY   = 1'b0;
    MM_RDATA = '0;
    exp_refill = '0;
    exp_stall  = '0;
    exp_err    = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (MM_REQ !== 1'b0 || MM_ADDR !== 32'h0 || Access_MM !== 1'b0 || Data_MM !== 32'h0 ||
        BUSY !== 1'b0 || ERR !== 1'b0 || CNT_REFILL !== '0 || CNT_STALL !== '0) begin
      errors++;
      $display("FAIL reset_values: got req=%b addr=%08h acc=%b data=%08h busy=%b err=%b ref=%0h stl=%0h expected all 0",
               MM_REQ, MM_ADDR, Access_MM, Data_MM, BUSY, ERR, CNT_REFILL, CNT_STALL);
    end
    HitWrite = 1'b0;
    #1;
    checks++;
    if (STALL !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_follow: got %b expected 1", STALL);
    end
    HitWrite = 1'b1;
    @(negedge CLK);
    RESET_N = 1'b1;
    idle_cycles(2);

    run_miss(32'h0000_1008, 32'h1234_5678, 1);
    @(negedge CLK);
    PC       = 32'h0000_0030;
    HitWrite = 1'b0;
    MM_RDY   = 1'b0;
    @(negedge CLK);
    HitWrite = 1'b1;
    #1;
    checks++;
    if (MM_REQ !== 1'b1 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_req: got req=%b busy=%b expected 1 1", MM_REQ, BUSY);
    end
    #1;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (MM_REQ !== 1'b0 || BUSY !== 1'b0 || Access_MM !== 1'b0 ||
        CNT_REFILL !== '0 || CNT_STALL !== '0 || STALL !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got req=%b busy=%b acc=%b ref=%0h stl=%0h stall=%b expected all 0",
               MM_REQ, BUSY, Access_MM, CNT_REFILL, CNT_STALL, STALL);
    end
    @(negedge CLK);
    RESET_N    = 1'b1;
    exp_refill = '0;
    exp_stall  = '0;
    idle_cycles(2);
  endtask

  task automatic test_zero_wait();
    apply_reset();
    run_miss(32'h0000_0014, 32'hDEAD_BEEF, 0);
    idle_cycles(1);
    checks++;
    if (CNT_REFILL !== 20'd1 || CNT_STALL !== 20'd4) begin
      errors++;
      $display("FAIL zero_wait_counts: got refill=%0d stall=%0d expected 1 4", CNT_REFILL, CNT_STALL);
    end
  endtask

  task automatic test_wait_states();
    apply_reset();
    run_miss(32'h0000_0A1C, 32'hCAFE_F00D, 3);
    idle_cycles(1);
    checks++;
    if (CNT_STALL !== 20'd7 || CNT_REFILL !== 20'd1) begin
      errors++;
      $display("FAIL wait_counts: got stall=%0d refill=%0d expected 7 1", CNT_STALL, CNT_REFILL);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    run_miss(32'h0000_0020, 32'hA5A5_0001, 1);
    run_miss(32'h0000_0044, 32'hA5A5_0002, 1);
    idle_cycles(1);
    checks++;
    if (CNT_REFILL !== 20'd2 || CNT_STALL !== 20'd10) begin
      errors++;
      $display("FAIL b2b_counts: got refill=%0d stall=%0d expected 2 10", CNT_REFILL, CNT_STALL);
    end
  endtask

  task automatic test_random();
    int gap;
    apply_reset();
    for (int n = 0; n < 24; n++) begin
      run_miss($urandom, $urandom, int'($urandom_range(0, 5)));
      gap = int'($urandom_range(0, 2));
      idle_cycles(gap);
    end
    idle_cycles(1);
  endtask

`ifdef ICACHE_REFILL_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    @(negedge CLK);
    PC       = 32'h0000_0108;
    HitWrite = 1'b0;
    MM_RDY   = 1'b0;
    #1;
    exp_stall = sat_inc(exp_stall);
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge CLK);
      HitWrite = 1'($urandom);
      MM_RDY   = 1'b0;
      #1;
      checks++;
      if (MM_REQ !== 1'b1 || ERR !== 1'b0 || Access_MM !== 1'b0) begin
        errors++;
        $display("FAIL timeout_req: got req=%b err=%b acc=%b expected 1 0 0", MM_REQ, ERR, Access_MM);
      end
      exp_stall = sat_inc(exp_stall);
    end
    exp_err = 1'b1;
    run_miss(32'h0000_0108, 32'h0BAD_F00D, 0);
    idle_cycles(2);
  endtask
`endif

  task automatic test_saturation();
    apply_reset();
    @(negedge CLK);
    HitWrite = 1'b1;
    force dut.r_cnt_stall = 20'hFFFFE;
    #1;
    release dut.r_cnt_stall;
    exp_stall = 20'hFFFFE;
    run_miss(32'h0000_0004, 32'h5555_AAAA, 0);
    idle_cycles(3);
    checks++;
    if (CNT_STALL !== 20'hFFFFF) begin
      errors++;
      $display("FAIL saturation: got %0h expected fffff", CNT_STALL);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_back_to_back();
    test_random();
`ifdef ICACHE_REFILL_TIMEOUT_EN
    test_timeout();
`endif
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss/refill sequencer for the 8-entry direct-mapped instruction cache. It watches the cache's hit indication and drives the cache's `index`, `Access_MM` and `Data_MM` inputs. On a miss it stalls fetch, runs a request/ready transaction to main memory for the missing word, strobes the word into the cache, then releases the stall. It also keeps refill and stall-cycle statistics for performance checking.

## Interface
Parameters:
- `INDEX_W`, 3: cache index width; the index is `PC[INDEX_W+1:2]`.
- `CNT_W`, 20: statistics counter width.
- `TIMEOUT`, 64: cycles `MM_REQ` may stay high without `MM_RDY` (used only with the macro).

Ports:
- `CLK` in 1: clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `PC` in 32: fetch address.
- `HitWrite` in 1: cache hit flag. 1 = hit or fill; 0 = miss.
- `MM_RDY` in 1: memory data valid; completes the request.
- `MM_RDATA` in 32: memory read data; sampled when `MM_RDY`=1.
- `MM_REQ` out 1: memory read request.
- `MM_ADDR` out 32: word-aligned miss address.
- `index` out INDEX_W: cache index.
- `Access_MM` out 1: one-cycle cache fill strobe.
- `Data_MM` out 32: fill data to the cache.
- `STALL` out 1: freezes PC and the IF/ID register.
- `BUSY` out 1: refill in progress (state ≠ IDLE).
- `ERR` out 1: sticky memory-timeout flag.
- `CNT_REFILL` out CNT_W: completed refills.
- `CNT_STALL` out CNT_W: stall cycles.

## Operation
FSM states: IDLE, REQ, FILL, SETTLE.

- **IDLE**
  - `index` is combinational from `PC[INDEX_W+1:2]`.
  - If `HitWrite`=0: latch `MA = {PC[31:2],2'b00}` and the index, then go to REQ.
  - `STALL = ~HitWrite` (combinational), so the pipeline freezes in the miss-detect cycle.
- **REQ**
  - `MM_REQ`=1 and `MM_ADDR`=MA, both registered and held stable until `MM_RDY`.
  - When `MM_RDY`=1: capture `MM_RDATA` into `Data_MM`, drop `MM_REQ`, go to FILL.
  - `MM_RDY` in the same cycle `MM_REQ` first rises is accepted (zero-wait memory).
- **FILL**
  - `Access_MM`=1 for exactly one cycle, with `index` = latched index and `Data_MM` = captured word.
  - `CNT_REFILL` increments. Go to SETTLE.
- **SETTLE**
  - One cycle with `HitWrite` ignored, so the cache's registered hit flag can update. Go to IDLE.
- `STALL`=1 in REQ, FILL and SETTLE.
- `index` holds the latched value for the whole time state ≠ IDLE.
- `MM_RDY` outside REQ is ignored. `MM_RDATA` is don't-care except when sampled.
- `CNT_STALL` increments every cycle `STALL`=1.
- Both counters saturate at all-ones; they never wrap.
- `PC` changes while state ≠ IDLE have no effect.

## Timing
- Reset values: state IDLE, `MM_REQ`=0, `MM_ADDR`=0, `Access_MM`=0, `Data_MM`=0, `BUSY`=0, `ERR`=0, both counters 0, latched index 0.
- While IDLE after reset, `STALL` follows `~HitWrite`.
- Miss with W memory wait cycles (`MM_RDY` arriving W cycles after `MM_REQ` rises): `STALL` is high for exactly 4+W cycles. That is the detect cycle, then REQ (1+W cycles), then FILL, then SETTLE.
- `Access_MM` rises 1+W cycles after `MM_REQ` rises.
- Back-to-back misses: the first IDLE cycle after SETTLE samples `HitWrite` again. A new miss starts the next refill with no extra gap.
- Reset asserted mid-refill: all outputs return to reset values immediately (asynchronously). An outstanding memory request is abandoned, and memory must tolerate `MM_REQ` falling without `MM_RDY`.

## Configuration
Macro `ICACHE_REFILL_TIMEOUT_EN`.

- **Defined**
  - A counter runs while in REQ.
  - If `MM_RDY` has not arrived after `TIMEOUT` cycles, then on the next edge: `MM_REQ`→0, `ERR`→1 (sticky until reset), go to IDLE with no fill.
  - The fetch re-misses, so the refill is retried automatically.
- **Undefined**
  - REQ waits indefinitely.
  - `ERR` is tied to 0 and no timeout counter is built.

## Test plan
- **Reset:** `RESET_N`=0 mid-REQ → `MM_REQ`, `BUSY`, `Access_MM` and both counters read 0 in the same cycle; IDLE after release.
- **Zero-wait miss:** PC=0x0000_0014, `HitWrite`=0, `MM_RDY` high with `MM_RDATA`=0xDEAD_BEEF in the first REQ cycle.
  - `MM_ADDR`=0x0000_0014.
  - `Access_MM` pulses 1 cycle with `index`=5 and `Data_MM`=0xDEAD_BEEF.
  - `STALL` high for 4 cycles; `CNT_REFILL`=1, `CNT_STALL`=4.
- **Wait states:** `MM_RDY` delayed 3 cycles → `MM_REQ` and `MM_ADDR` are stable for 4 cycles, `STALL` is high for 7 cycles, and a PC change during REQ does not alter `index`.
- **Back-to-back misses:** PC 0x20 then 0x44, each with 1 wait cycle → two fills at `index` 0 then 1, `CNT_REFILL`=2, `CNT_STALL`=10.
- **Timeout (macro defined, `TIMEOUT`=8):** `MM_RDY` held 0 → `MM_REQ` drops after 8 cycles, `ERR`=1, no `Access_MM` pulse. On the retry with `MM_RDY`=1 the fill completes and `ERR` stays 1.
- **Saturation:** force `CNT_STALL` to 0xFFFFE, then stall 3 cycles → it reads 0xFFFFF and holds.
